// File: rtl/led_seq.sv
// LED pattern sequencer: static, blink, chase and bounce frames at a programmable step rate.
// Optional PWM brightness gating is enabled by defining LED_SEQ_PWM_EN.
module led_seq #(
  parameter int LED_NUM = 4,
  parameter int CNT_W   = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] period,
  input  logic [31:0]      pattern,
`ifdef LED_SEQ_PWM_EN
  input  logic [7:0]       brightness,
`endif
  output logic [31:0]      led_state,
  output logic             step,
  output logic             busy
);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  typedef enum logic [1:0] {
    M_STATIC = 2'd0,
    M_BLINK  = 2'd1,
    M_CHASE  = 2'd2,
    M_BOUNCE = 2'd3
  } mode_t;

  localparam logic [31:0] MASK =
    (LED_NUM >= 32) ? 32'hFFFF_FFFF
                    : ((32'd1 << LED_NUM) - 32'd1);
  localparam logic [4:0] LAST = 5'(LED_NUM - 1);

  state_t           r_state;
  mode_t            r_mode;
  logic [CNT_W-1:0] r_cnt;
  logic [4:0]       r_pos;
  logic             r_down;
  logic             r_off;
  logic             r_start;
  logic [31:0]      r_led;
  logic             r_step;
  logic             r_busy;

  logic             w_tick;
  logic             w_adv;
  logic [4:0]       w_pos_n;
  logic             w_down_n;
  logic             w_off_n;
  logic [31:0]      w_frame;
  logic             w_gate;

  assign w_tick = (r_cnt == period);
  // The first cycle after a (re)start shows position 0 without advancing.
  assign w_adv  = w_tick & ~r_start;

  always_comb begin
    w_pos_n  = r_pos;
    w_down_n = r_down;
    w_off_n  = r_off;
    if (w_adv) begin
      unique case (r_mode)
        M_BLINK: w_off_n = ~r_off;
        M_CHASE: w_pos_n = (r_pos == LAST) ? 5'd0 : r_pos + 5'd1;
        M_BOUNCE: begin
          if (LED_NUM > 1) begin
            if (!r_down) begin
              if (r_pos == LAST) begin
                w_pos_n  = r_pos - 5'd1;
                w_down_n = 1'b1;
              end else begin
                w_pos_n = r_pos + 5'd1;
              end
            end else begin
              if (r_pos == 5'd0) begin
                w_pos_n  = 5'd1;
                w_down_n = 1'b0;
              end else begin
                w_pos_n = r_pos - 5'd1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_frame = '0;
    unique case (r_mode)
      M_STATIC: w_frame = pattern & MASK;
      M_BLINK:  w_frame = w_off_n ? 32'd0 : (pattern & MASK);
      default:  w_frame = (32'd1 << w_pos_n) & MASK;
    endcase
  end

`ifdef LED_SEQ_PWM_EN
  logic [7:0] r_pwm;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_pwm <= '0;
    else       r_pwm <= r_pwm + 8'd1;
  end

  assign w_gate = (r_pwm < brightness);
`else
  assign w_gate = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_mode  <= M_STATIC;
      r_cnt   <= '0;
      r_pos   <= '0;
      r_down  <= 1'b0;
      r_off   <= 1'b0;
      r_start <= 1'b0;
      r_led   <= '0;
      r_step  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_led   <= '0;
          r_step  <= 1'b0;
          r_cnt   <= '0;
          r_pos   <= '0;
          r_down  <= 1'b0;
          r_off   <= 1'b0;
          if (enable) begin
            r_state <= S_RUN;
            r_busy  <= 1'b1;
            r_mode  <= mode_t'(mode);
            r_start <= 1'b1;
          end else begin
            r_busy  <= 1'b0;
            r_start <= 1'b0;
          end
        end
        S_RUN: begin
          if (!enable) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_step  <= 1'b0;
            r_start <= 1'b0;
            r_cnt   <= '0;
            r_pos   <= '0;
            r_down  <= 1'b0;
            r_off   <= 1'b0;
          end else if (mode_t'(mode) != r_mode) begin
            r_mode  <= mode_t'(mode);
            r_start <= 1'b1;
            r_step  <= 1'b0;
            r_cnt   <= '0;
            r_pos   <= '0;
            r_down  <= 1'b0;
            r_off   <= 1'b0;
          end else begin
            r_start <= 1'b0;
            r_cnt   <= w_tick ? '0 : r_cnt + 1'b1;
            r_step  <= w_tick;
            r_pos   <= w_pos_n;
            r_down  <= w_down_n;
            r_off   <= w_off_n;
            r_led   <= w_gate ? w_frame : 32'd0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign led_state = r_led;
  assign step      = r_step;
  assign busy      = r_busy;

endmodule

// File: tb/tb_led_seq.sv
// Directed bench for led_seq (LED_NUM=4, CNT_W=8 so counter wrap fits a short run).
// PWM vectors are added when LED_SEQ_PWM_EN is defined.
module tb_led_seq;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [1:0]  mode;
  logic [7:0]  period;
  logic [31:0] pattern;
  logic [7:0]  brightness;
  logic [31:0] led_state;
  logic        step;
  logic        busy;

  int n_vec;
  int n_err;

  led_seq #(
    .LED_NUM(4),
    .CNT_W  (8)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .mode      (mode),
    .period    (period),
    .pattern   (pattern),
`ifdef LED_SEQ_PWM_EN
    .brightness(brightness),
`endif
    .led_state (led_state),
    .step      (step),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // advance n clock edges, leaving time 1 unit after the last edge
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [31:0] exp_led;
  logic [31:0] acc;
  int          first_k;
  int          n_steps;
  int          on_cnt;
  int          seq_b[6] = '{0, 1, 2, 3, 2, 1};

  initial begin
    n_vec      = 0;
    n_err      = 0;
    reset      = 1'b1;
    enable     = 1'b0;
    mode       = 2'd0;
    period     = 8'd0;
    pattern    = 32'd0;
    brightness = 8'd255;
    cyc(3);
    check("rst_led", led_state, 32'd0);
    check("rst_step", {31'd0, step}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;

    acc = '0;
    for (int i = 0; i < 100; i++) begin
      cyc(1);
      acc = acc | led_state | {30'd0, step, busy};
    end
    check("idle_hold", acc, 32'd0);

    // STATIC
    pattern = 32'hFFFF_FFFA;
    period  = 8'd3;
    mode    = 2'd0;
    enable  = 1'b1;
    cyc(1);
    check("st_busy", {31'd0, busy}, 32'd1);
    check("st_led_n", led_state, 32'd0);
    for (int k = 1; k <= 12; k++) begin
      cyc(1);
      check("st_led", led_state, 32'h0000_000A);
      check("st_step", {31'd0, step}, {31'd0, (k % 4) == 0});
    end
    enable = 1'b0;
    cyc(1);
    check("st_off_busy", {31'd0, busy}, 32'd0);
    cyc(1);
    check("st_off_led", led_state, 32'd0);
    cyc(2);

    // BLINK
    pattern = 32'h5;
    period  = 8'd2;
    mode    = 2'd1;
    enable  = 1'b1;
    cyc(1);
    for (int k = 1; k <= 12; k++) begin
      cyc(1);
      exp_led = ((k / 3) % 2 == 0) ? 32'h5 : 32'h0;
      check("bl_led", led_state, exp_led);
      check("bl_step", {31'd0, step}, {31'd0, (k % 3) == 0});
    end
    enable = 1'b0;
    cyc(3);

    // CHASE, period 0
    period = 8'd0;
    mode   = 2'd2;
    enable = 1'b1;
    cyc(1);
    for (int k = 1; k <= 9; k++) begin
      cyc(1);
      check("ch_led", led_state, 32'd1 << ((k - 1) % 4));
      check("ch_step", {31'd0, step}, 32'd1);
    end

    // switch to BOUNCE mid-sequence
    mode = 2'd3;
    cyc(1);
    for (int k = 1; k <= 9; k++) begin
      cyc(1);
      check("bo_led", led_state, 32'd1 << seq_b[(k - 1) % 6]);
    end

    // back to CHASE mid-bounce, then drop enable at pos 2
    mode = 2'd2;
    cyc(2);
    check("sw_restart", led_state, 32'd1);
    cyc(1);
    check("sw_pos1", led_state, 32'd2);
    cyc(1);
    check("sw_pos2", led_state, 32'd4);
    enable = 1'b0;
    cyc(1);
    check("dis_busy", {31'd0, busy}, 32'd0);
    cyc(1);
    check("dis_led", led_state, 32'd0);
    enable = 1'b1;
    cyc(2);
    check("reen_led", led_state, 32'd1);
    enable = 1'b0;
    cyc(3);

    // live period lowering while cnt=5 forces one wrap
    period = 8'd10;
    enable = 1'b1;
    cyc(1);
    cyc(5);
    period  = 8'd1;
    first_k = -1;
    n_steps = 0;
    for (int k = 6; k <= 262; k++) begin
      cyc(1);
      if (step) begin
        n_steps++;
        if (first_k < 0) first_k = k;
      end
    end
    check("wrap_first", first_k, 258);
    check("wrap_nstep", n_steps, 3);
    check("wrap_led", led_state, 32'd8);

    // asynchronous reset mid-run
    #2;
    reset = 1'b1;
    #1;
    check("arst_led", led_state, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_step", {31'd0, step}, 32'd0);
    enable = 1'b0;
    cyc(2);
    reset = 1'b0;
    cyc(2);

`ifdef LED_SEQ_PWM_EN
    pattern    = 32'hF;
    period     = 8'd0;
    mode       = 2'd0;
    brightness = 8'd64;
    enable     = 1'b1;
    cyc(4);
    on_cnt = 0;
    acc    = '0;
    for (int i = 0; i < 256; i++) begin
      cyc(1);
      if (led_state == 32'hF) on_cnt++;
      else acc = acc | led_state;
    end
    check("pwm64_on", on_cnt, 64);
    check("pwm64_off", acc, 32'd0);
    brightness = 8'd0;
    cyc(2);
    acc = '0;
    for (int i = 0; i < 256; i++) begin
      cyc(1);
      acc = acc | led_state;
    end
    check("pwm0", acc, 32'd0);
    enable = 1'b0;
    cyc(2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/led_seq.md
# led_seq

Pattern sequencer that drives the `led_state` register input of the LED controller. It generates static, blinking, chasing and bouncing LED frames, stepping at a programmable rate. It sits between the CPU-facing register bank, which supplies mode, period and pattern, and the LED controller, which registers `led_state` onto the pins.

## Interface

Parameters:
- `LED_NUM`, default 4: number of driven LEDs. Legal range is 1..32.
- `CNT_W`, default 24: width of the step-period counter.

Ports:
- `clk`  in  1: system clock.
- `reset`  in  1: asynchronous, active-high reset.
- `enable`  in  1: run the sequencer. Low forces idle.
- `mode`  in  2: 0 STATIC, 1 BLINK, 2 CHASE, 3 BOUNCE.
- `period`  in  CNT_W: a step occurs every `period`+1 clocks.
- `pattern`  in  32: frame source for STATIC and BLINK. Only bits [LED_NUM-1:0] are used.
- `brightness`  in  8: PWM duty. Present only with `LED_SEQ_PWM_EN`.
- `led_state`  out  32: frame for the LED controller. Bits [31:LED_NUM] are always 0.
- `step`  out  1: one-cycle pulse at each sequence step.
- `busy`  out  1: high while in RUN.

## Operation

- Two-state FSM: IDLE and RUN.
  - IDLE → RUN when `enable`=1.
  - RUN → IDLE when `enable`=0.
- Entering RUN clears the following, then the sequence starts:
  - period counter `cnt`=0
  - position `pos`=0
  - direction = up
  - blink phase = on
- Period counter in RUN:
  - `cnt` increments each clock.
  - When `cnt`==`period`, `cnt`←0 and a tick occurs.
  - `period`=0 gives a tick every clock.
  - `period` is sampled live. If it is lowered below `cnt`, `cnt` runs on to its maximum value, wraps to 0, and continues.
- Frame by mode, advancing only on a tick:
  - STATIC: frame = `pattern`. Ticks still produce `step`.
  - BLINK: frame = `pattern` when phase is on, 0 when off. Phase toggles each tick, starting on.
  - CHASE: frame = one-hot(`pos`). `pos` advances 0,1,…,LED_NUM-1, then wraps to 0.
  - BOUNCE: frame = one-hot(`pos`).
    - `pos` counts up to LED_NUM-1, then down to 0, then up again. End LEDs are not repeated: 0,1,2,3,2,1,0,1…
    - LED_NUM=1: `pos` stays 0 in both CHASE and BOUNCE.
- Changing `mode` while in RUN restarts the sequence on the next clock. This clears `cnt`, `pos`, direction and phase, as on RUN entry.
- A `pattern` change takes effect on the next clock without a restart.
- IDLE outputs: `led_state`=0, `step`=0, `busy`=0. Counters are held at 0.
- `led_state` is fully registered.

## Timing

- Reset values: `led_state`=0, `step`=0, `busy`=0, FSM=IDLE, all counters 0.
- Reset asserted in the middle of a sequence returns immediately (asynchronously) to these values.
- `enable` sampled high at edge N:
  - `busy`=1 after edge N.
  - First frame (pos 0 / pattern) on `led_state` after edge N+1.
- First tick: `step` is high for the cycle after edge N+1+`period`, and the new frame appears on `led_state` in that same cycle.
- `step` and the frame update are aligned to the same edge.
- `enable` sampled low at edge M: `busy`=0 after M, and `led_state`=0 after edge M+1.
- Mode change sampled at edge K: the restarted first frame appears after edge K+1.

## Configuration

- Macro: `LED_SEQ_PWM_EN`.
- Defined:
  - Adds the `brightness` port and an 8-bit free-running PWM counter `pwm`, which resets to 0.
  - Each frame bit is output only while `pwm` < `brightness`.
  - `brightness`=0 gives all LEDs off. 128 gives a 50 % duty. 255 gives 255/256 duty.
  - PWM gating is applied in the `led_state` output register. It is independent of `step`.
- Undefined: no `brightness` port, no PWM counter, and the frame is output ungated.

## Test plan

- Reset then idle: assert `reset` mid-run → `led_state`=0, `step`=0, `busy`=0 immediately. With `enable`=0 held 100 clocks, outputs stay 0.
- STATIC: `pattern`=0xFFFF_FFFA, LED_NUM=4, `period`=3 → `led_state`=0x0000_000A two clocks after `enable` is sampled. `step` pulses every 4 clocks.
- BLINK: `pattern`=0x5, `period`=2 → `led_state` alternates 0x5/0x0 every 3 clocks. Each change coincides with `step`.
- CHASE, then BOUNCE with `period`=0:
  - CHASE → `led_state` sequence 1,2,4,8,1…
  - BOUNCE → 1,2,4,8,4,2,1,2…
  - Switching mode mid-sequence restarts at 1.
- Enable drop and live period: drop `enable` at pos 2 → `led_state`=0 next clock. Re-enable → restarts at 1. Change `period` 10→1 while `cnt`=5 → `cnt` wraps once, then ticks every 2 clocks.
- PWM (`LED_SEQ_PWM_EN`), STATIC `pattern`=0xF:
  - `brightness`=64 → LEDs on for 64 of each 256 clocks.
  - `brightness`=0 → always 0.
